// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-search controller.
package rc4_pkg;

    // Scheduler states: one GO/WAIT pair per phase, then evaluation and the two terminal states.
    typedef enum logic [3:0] {
        IDLE,
        INIT_GO,
        INIT_WAIT,
        KSA_GO,
        KSA_WAIT,
        PRGA_GO,
        PRGA_WAIT,
        EVAL,
        FOUND,
        EXHAUSTED
    } search_state_t;

    // Which phase currently drives the single-port S-RAM.
    typedef enum logic [1:0] {
        NONE,
        INIT,
        KSA,
        PRGA
    } sram_owner_t;

    localparam logic [7:0] CHAR_SPACE = 8'd32;
    localparam logic [7:0] CHAR_LO    = 8'd97;
    localparam logic [7:0] CHAR_HI    = 8'd122;

    // Plaintext is accepted only if every byte is a space or a lowercase letter.
    function automatic logic is_valid_char(input logic [7:0] ch);
        return (ch == CHAR_SPACE) || ((ch >= CHAR_LO) && (ch <= CHAR_HI));
    endfunction

endpackage

// File: rtl/rc4_sram_mux.sv
// Combinational S-RAM port arbiter: passes the owning phase's request straight
// through and parks the port (all zeros) when nobody owns it.
module rc4_sram_mux
    import rc4_pkg::*;
(
    input  sram_owner_t owner_i,
    input  logic [7:0]  init_addr_i,
    input  logic [7:0]  init_data_i,
    input  logic        init_wren_i,
    input  logic [7:0]  ksa_addr_i,
    input  logic [7:0]  ksa_data_i,
    input  logic        ksa_wren_i,
    input  logic [7:0]  prga_addr_i,
    input  logic [7:0]  prga_data_i,
    input  logic        prga_wren_i,
    output logic [7:0]  s_address_o,
    output logic [7:0]  s_data_o,
    output logic        s_wren_o
);

    // Zero-latency select; non-owners never reach the port, so their wren is effectively forced low.
    always_comb begin
        s_address_o = 8'd0;
        s_data_o    = 8'd0;
        s_wren_o    = 1'b0;
        case (owner_i)
            INIT: begin
                s_address_o = init_addr_i;
                s_data_o    = init_data_i;
                s_wren_o    = init_wren_i;
            end
            KSA: begin
                s_address_o = ksa_addr_i;
                s_data_o    = ksa_data_i;
                s_wren_o    = ksa_wren_i;
            end
            PRGA: begin
                s_address_o = prga_addr_i;
                s_data_o    = prga_data_i;
                s_wren_o    = prga_wren_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// RC4 key-search scheduler: runs init, KSA and PRGA for each candidate key,
// screens every decrypted byte and advances the key until a plaintext passes
// or the key space runs out.
module rc4_key_search_ctrl
    import rc4_pkg::*;
#(
    parameter int                   KEY_WIDTH      = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX        = 24'h3FFFFF,
    parameter int                   MESSAGE_LENGTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    output logic                 done,
    output logic                 found,
    output logic [KEY_WIDTH-1:0] key,
    output logic                 init_start,
    output logic                 ksa_start,
    output logic                 prga_start,
    input  logic                 init_finish,
    input  logic                 ksa_finish,
    input  logic                 prga_finish,
    input  logic [7:0]           init_addr,
    input  logic [7:0]           init_data,
    input  logic                 init_wren,
    input  logic [7:0]           ksa_addr,
    input  logic [7:0]           ksa_data,
    input  logic                 ksa_wren,
    input  logic [7:0]           prga_addr,
    input  logic [7:0]           prga_data,
    input  logic                 prga_wren,
    output logic [7:0]           s_address,
    output logic [7:0]           s_data,
    output logic                 s_wren,
    input  logic                 prga_decrypt_wren
);

    // Message length is informational only (PRGA signals its own completion); reject nonsense values.
    if (MESSAGE_LENGTH < 1) begin : g_bad_length
        $error("rc4_key_search_ctrl: MESSAGE_LENGTH must be at least 1");
    end

    search_state_t        state_q, state_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic                 bad_q, bad_d;
    sram_owner_t          owner;

    // State, key counter and bad-byte flag registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            key_q   <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            bad_q   <= bad_d;
        end
    end

    // Next-state logic plus the one-cycle start pulses, which are pure decodes of the GO states.
    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        bad_d      = bad_q;
        init_start = 1'b0;
        ksa_start  = 1'b0;
        prga_start = 1'b0;
        case (state_q)
            IDLE, FOUND, EXHAUSTED: begin
                if (start) begin
                    state_d = INIT_GO;
                    key_d   = '0;
                end
            end
            INIT_GO: begin
                init_start = 1'b1;
                bad_d      = 1'b0;
                state_d    = INIT_WAIT;
            end
            INIT_WAIT: if (init_finish) state_d = KSA_GO;
            KSA_GO: begin
                ksa_start = 1'b1;
                state_d   = KSA_WAIT;
            end
            KSA_WAIT: if (ksa_finish) state_d = PRGA_GO;
            PRGA_GO: begin
                prga_start = 1'b1;
                state_d    = PRGA_WAIT;
            end
            PRGA_WAIT: begin
                // PRGA always runs to completion; a bad byte is only remembered.
                if (prga_decrypt_wren && !is_valid_char(prga_data)) bad_d = 1'b1;
                if (prga_finish) state_d = EVAL;
            end
            EVAL: begin
                if (!bad_q) begin
                    state_d = FOUND;
                end else if (key_q == KEY_MAX) begin
                    state_d = EXHAUSTED;
                end else begin
                    key_d   = key_q + KEY_WIDTH'(1);
                    state_d = INIT_GO;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // S-RAM ownership follows the phase the scheduler is in.
    always_comb begin
        case (state_q)
            INIT_GO, INIT_WAIT: owner = INIT;
            KSA_GO, KSA_WAIT:   owner = KSA;
            PRGA_GO, PRGA_WAIT: owner = PRGA;
            default:            owner = NONE;
        endcase
    end

    rc4_sram_mux u_sram_mux (
        .owner_i     (owner),
        .init_addr_i (init_addr),
        .init_data_i (init_data),
        .init_wren_i (init_wren),
        .ksa_addr_i  (ksa_addr),
        .ksa_data_i  (ksa_data),
        .ksa_wren_i  (ksa_wren),
        .prga_addr_i (prga_addr),
        .prga_data_i (prga_data),
        .prga_wren_i (prga_wren),
        .s_address_o (s_address),
        .s_data_o    (s_data),
        .s_wren_o    (s_wren)
    );

    assign key   = key_q;
    assign found = (state_q == FOUND);
    assign done  = (state_q == FOUND) || (state_q == EXHAUSTED);

endmodule
